// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : Host-to-device PS/2 transmitter. Drives the open-collector PS/2
//            clock/data lines (through output enables) to send one command
//            byte to a keyboard. Bytes arrive on a valid/ready handshake and
//            completion/failure is reported with one-cycle pulses.
// Options  : PS2_TX_TIMEOUT_EN - compile in a per-transfer watchdog that
//            aborts to IDLE with tx_error after TIMEOUT_CYCLES clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   // -------------------------------------------------------------------------
   // Constants and types
   // -------------------------------------------------------------------------
   localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);

   // Index of the stop bit inside the 10-bit frame; once it is presented the
   // next device clock fall carries the acknowledge.
   localparam logic [3:0] c_stop_idx = 4'd9;
   localparam logic [3:0] c_ack_fall = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INHIBIT = 3'd1,
      ST_REQ     = 3'd2,
      ST_BITS    = 3'd3,
      ST_ACK     = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   // -------------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------------
   // Pin synchronizers (reset to the idle-high bus level)
   logic               r_clk_meta;
   logic               r_clk_sync;
   logic               r_clk_prev;
   logic               r_data_meta;
   logic               r_data_sync;

   // FSM and datapath state
   state_t             r_state;
   logic [9:0]         r_frame;
   logic [3:0]         r_bit_cnt;
   logic [c_inh_w-1:0] r_inh_cnt;
   logic               r_clk_oe;
   logic               r_data_oe;
   logic               r_tx_done;
   logic               r_tx_error;
   logic               r_ack_ok;
   logic               r_idle_seen;

   // Next-state values
   state_t             w_state_nxt;
   logic [9:0]         w_frame_nxt;
   logic [3:0]         w_bit_cnt_nxt;
   logic [c_inh_w-1:0] w_inh_cnt_nxt;
   logic               w_clk_oe_nxt;
   logic               w_data_oe_nxt;
   logic               w_done_nxt;
   logic               w_error_nxt;
   logic               w_ack_nxt;
   logic               w_idle_seen_nxt;

   // Decoded conditions
   logic               w_fall;
   logic               w_lines_idle;
   logic               w_accept;
   logic               w_timeout;

   // -------------------------------------------------------------------------
   // Input conditioning
   // -------------------------------------------------------------------------
   // Two-flop synchronizers on both pins plus a delayed clock copy for edges.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_clk_prev  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= ps2_clk_in;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= ps2_data_in;
         r_data_sync <= r_data_meta;
      end
   end

   // Device clock falling edge, seen two cycles after the pin moves.
   assign w_fall       = r_clk_prev & ~r_clk_sync;
   // Bus is idle when nobody pulls either line low.
   assign w_lines_idle = r_clk_sync & r_data_sync;

   // Ready only in IDLE and not during the completion/error pulse, so ready
   // rises the cycle after the pulse.
   assign tx_ready = (r_state == ST_IDLE) & ~r_tx_done & ~r_tx_error;
   assign w_accept = tx_valid & tx_ready;

   // -------------------------------------------------------------------------
   // Transfer watchdog
   // -------------------------------------------------------------------------
`ifdef PS2_TX_TIMEOUT_EN
   localparam int c_wdog_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYCLES - 1);

   logic [c_wdog_w-1:0] r_wdog;

   // Counts every cycle spent outside IDLE, restarted on each accepted byte.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wdog <= '0;
      end else if (w_accept) begin
         r_wdog <= '0;
      end else if (r_state != ST_IDLE) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   // Fires on the TIMEOUT_CYCLES-th busy cycle so the abort lands exactly
   // TIMEOUT_CYCLES edges after acceptance.
   assign w_timeout = (r_state != ST_IDLE) && (r_wdog == c_wdog_last);
`else
   // Without the watchdog a silent device parks the block until reset.
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
   assign w_timeout        = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   // Next-state and next-output decode; line enables are registered so every
   // data change lands one cycle after the synchronized fall.
   always_comb begin
      w_state_nxt     = r_state;
      w_frame_nxt     = r_frame;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_inh_cnt_nxt   = r_inh_cnt;
      w_clk_oe_nxt    = r_clk_oe;
      w_data_oe_nxt   = r_data_oe;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;
      w_ack_nxt       = r_ack_ok;
      w_idle_seen_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_ack_nxt     = 1'b0;
            if (w_accept) begin
               // Frame = {stop, odd parity, data}; bit 0 goes out first.
               w_frame_nxt   = {1'b1, ~^tx_data, tx_data};
               w_bit_cnt_nxt = 4'd0;
               w_inh_cnt_nxt = '0;
               w_clk_oe_nxt  = 1'b1;
               w_state_nxt   = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            // Hold the clock low; on the last inhibit cycle add the start
            // bit. The clock is released one cycle later from REQ.
            w_clk_oe_nxt  = 1'b1;
            w_inh_cnt_nxt = r_inh_cnt + 1'b1;
            if (r_inh_cnt == c_inh_last) begin
               w_data_oe_nxt = 1'b1;
               w_state_nxt   = ST_REQ;
            end
         end

         ST_REQ: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b1;
            if (w_fall) begin
               w_data_oe_nxt = ~r_frame[0];
               w_bit_cnt_nxt = 4'd1;
               w_state_nxt   = ST_BITS;
            end
         end

         ST_BITS: begin
            w_clk_oe_nxt = 1'b0;
            if (w_fall) begin
               // Fall n presents frame[n-1]; the stop bit (1) is a release.
               w_data_oe_nxt = ~r_frame[r_bit_cnt];
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == c_stop_idx) begin
                  w_state_nxt = ST_ACK;
               end
            end
         end

         ST_ACK: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            if (w_fall) begin
               w_bit_cnt_nxt = c_ack_fall;
               if (!r_data_sync) begin
                  w_ack_nxt = 1'b1;
               end else begin
                  w_error_nxt = 1'b1;
               end
               w_state_nxt = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            // Wait for both lines high two cycles in a row before finishing.
            w_clk_oe_nxt    = 1'b0;
            w_data_oe_nxt   = 1'b0;
            w_idle_seen_nxt = w_lines_idle;
            if (w_lines_idle && r_idle_seen) begin
               w_done_nxt  = r_ack_ok;
               w_ack_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_ack_nxt     = 1'b0;
            w_state_nxt   = ST_IDLE;
         end
      endcase

      // Watchdog abort overrides whatever the current state decided,
      // including a fall arriving in the same cycle.
      if (w_timeout) begin
         w_clk_oe_nxt    = 1'b0;
         w_data_oe_nxt   = 1'b0;
         w_done_nxt      = 1'b0;
         w_error_nxt     = 1'b1;
         w_ack_nxt       = 1'b0;
         w_idle_seen_nxt = 1'b0;
         w_state_nxt     = ST_IDLE;
      end
   end

   // State, frame, counters and registered line enables / status pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_frame     <= '0;
         r_bit_cnt   <= 4'd0;
         r_inh_cnt   <= '0;
         r_clk_oe    <= 1'b0;
         r_data_oe   <= 1'b0;
         r_tx_done   <= 1'b0;
         r_tx_error  <= 1'b0;
         r_ack_ok    <= 1'b0;
         r_idle_seen <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame     <= w_frame_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_inh_cnt   <= w_inh_cnt_nxt;
         r_clk_oe    <= w_clk_oe_nxt;
         r_data_oe   <= w_data_oe_nxt;
         r_tx_done   <= w_done_nxt;
         r_tx_error  <= w_error_nxt;
         r_ack_ok    <= w_ack_nxt;
         r_idle_seen <= w_idle_seen_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_done     = r_tx_done;
   assign tx_error    = r_tx_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Directed bench for ps2_host_tx with a behavioural PS/2 device
//            (scaled-down device clock) on wired-AND bus lines.
// Options  : PS2_TX_TIMEOUT_EN selects the watchdog expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

   localparam int c_inhibit = 10;
   localparam int c_timeout = 1000;
   localparam int c_half    = 20;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;

   int n_checks     = 0;
   int n_errors     = 0;
   int done_cycles  = 0;
   int error_cycles = 0;
   int both_cycles  = 0;

   // Open-collector bus: either side can pull a line low.
   assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   ps2_host_tx #(
      .INHIBIT_CYCLES (c_inhibit),
      .TIMEOUT_CYCLES (c_timeout)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_error    (tx_error),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   // Pulse-cycle counters.
   always @(posedge clk) begin
      if (tx_done)             done_cycles  <= done_cycles + 1;
      if (tx_error)            error_cycles <= error_cycles + 1;
      if (tx_done && tx_error) both_cycles  <= both_cycles + 1;
   end

   // Hang guard.
   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a byte; returns on the negedge after the accepting edge.
   task automatic offer(input logic [7:0] b);
      int w;
      w = 0;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
   endtask

   // Device side: wait for request, clock 10 bits in, then ack (or not).
   // abort_at > 0 stops right after that fall with the clock held low.
   task automatic dev_frame(input logic do_ack, input int abort_at,
                            output logic [9:0] bits, output int lat);
      int w;
      bits = '0;
      lat  = -1;
      w    = 0;
      while (!(ps2_clk_in && !ps2_data_in) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("request_seen", (w < 200), 1'b1);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         if (i + 1 == abort_at) begin
            repeat (6) @(negedge clk);
            return;
         end
         for (int c = 0; c < c_half; c++) begin
            @(negedge clk);
            if (i == 0 && lat < 0 && ps2_data_in) lat = c + 1;
         end
         bits[i] = ps2_data_in;
         dev_clk = 1'b1;
         repeat (c_half) @(negedge clk);
      end
      tx_valid = 1'b0;
      if (do_ack) dev_data = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (c_half) @(negedge clk);
      dev_clk = 1'b1;
      repeat (c_half) @(negedge clk);
      dev_data = 1'b1;
   endtask

   // Wait for tx_ready; optionally require the done/error pulse right before.
   task automatic wait_ready(input string tag, input logic need_pulse);
      int   w;
      logic prev;
      w    = 0;
      prev = 1'b0;
      while (!tx_ready && w < 300) begin
         prev = tx_done | tx_error;
         @(negedge clk);
         w++;
      end
      check({tag, "_ready"}, tx_ready, 1'b1);
      if (need_pulse) check({tag, "_pulse_then_ready"}, prev, 1'b1);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] b, input logic ack,
                            input logic [9:0] exp_bits, input logic stuff);
      logic [9:0] bits;
      int         lat;
      int         d0;
      int         e0;
      d0 = done_cycles;
      e0 = error_cycles;
      offer(b);
      if (stuff) begin
         tx_data  = 8'hA5;
         tx_valid = 1'b1;
      end
      dev_frame(ack, 0, bits, lat);
      check({tag, "_bits"}, bits, exp_bits);
      wait_ready(tag, ack);
      check({tag, "_done_cnt"}, done_cycles - d0, ack ? 1 : 0);
      check({tag, "_error_cnt"}, error_cycles - e0, ack ? 0 : 1);
      if (stuff) begin
         repeat (5) @(negedge clk);
         check({tag, "_no_extra_transfer"}, {tx_ready, ps2_clk_oe}, 2'b10);
      end
   endtask

   initial begin
      logic [9:0] bits;
      int         lat;
      int         k;
      int         d0;
      int         e0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_state", {tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 5'b10000);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // 0xED with inhibit timing and data latency
      d0 = done_cycles;
      e0 = error_cycles;
      offer(8'hED);
      check("accept_ready_low", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b010);
      k = 0;
      while (ps2_clk_oe && !ps2_data_oe && k < 100) begin
         k++;
         @(negedge clk);
      end
      check("inhibit_len", k, c_inhibit);
      check("start_overlap", {ps2_clk_oe, ps2_data_oe}, 2'b11);
      @(negedge clk);
      check("clk_release", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      dev_frame(1'b1, 0, bits, lat);
      check("ed_bits", bits, 10'h3ED);
      check("ed_d0_latency", lat, 3);
      wait_ready("ed", 1'b1);
      check("ed_done_cnt", done_cycles - d0, 1);
      check("ed_error_cnt", error_cycles - e0, 0);

      // Parity corners, with a byte offered while busy on the first one
      run_frame("b00", 8'h00, 1'b1, 10'h300, 1'b1);
      run_frame("b01", 8'h01, 1'b1, 10'h201, 1'b0);

      // Missing acknowledge
      run_frame("noack", 8'h5A, 1'b0, 10'h35A, 1'b0);

      // Reset in the middle of a frame
      d0 = done_cycles;
      e0 = error_cycles;
      offer(8'hC3);
      dev_frame(1'b1, 5, bits, lat);
      check("mid_frame_drive", {tx_ready, ps2_data_oe}, 2'b01);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("reset_mid_frame", {tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 5'b10000);
      check("reset_no_pulses", (done_cycles - d0) + (error_cycles - e0), 0);
      dev_clk = 1'b1;
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      run_frame("bff", 8'hFF, 1'b1, 10'h3FF, 1'b0);

      // Silent device
      e0 = error_cycles;
      d0 = done_cycles;
      offer(8'h12);
`ifdef PS2_TX_TIMEOUT_EN
      k = 0;
      while (!tx_error && k < 1500) begin
         @(negedge clk);
         k++;
      end
      check("timeout_cycle", k, c_timeout);
      check("timeout_lines", {ps2_clk_oe, ps2_data_oe, tx_done}, 3'b000);
      @(negedge clk);
      check("timeout_ready", {tx_ready, tx_error}, 2'b10);
      check("timeout_error_cnt", error_cycles - e0, 1);
`else
      repeat (2000) @(negedge clk);
      check("stuck_in_req", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b001);
      check("stuck_no_pulse", (error_cycles - e0) + (done_cycles - d0), 0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("stuck_reset_ready", tx_ready, 1'b1);
`endif

      check("never_both_pulses", both_cycles, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
